adc_frame_align: RTL
====================

// Module: adc_frame_align
// PURPOSE
//  Frame-clock alignment controller in the ADC LVDS receive path, FrmClkDiv domain.
//  Watches the 14-bit deserialised frame word and pulses bitslip to the frame and data
//  deserialisers until the word equals the expected frame pattern.
//  Drives the data-capture stage's DatBitslip and FrmAlignDone inputs.
// PARAMETERS
//  FRM_WIDTH     14                 frame word width (bits)
//  FRM_PATTERN   14'b11111110000000 expected aligned frame word
//  SETTLE_CYCLES 4                  cycles waited after each slip (or start) before comparing, >=1
//  MATCH_COUNT   8                  consecutive matches required for lock, >=1
//  MAX_SLIPS     13                 slips tried before declaring failure, <=15
//  LOSS_COUNT    4                  consecutive mismatches that drop lock (monitor only)
// PORTS
//  FrmClkDiv    in  1          divided frame clock; the only clock
//  FrmRstN      in  1          reset, asynchronous assert, active-low
//  FrmStart     in  1          one-cycle pulse: abandon current state, restart alignment
//  FrmData      in  FRM_WIDTH  deserialised frame word, valid every cycle
//  FrmBitslip   out 1          one-cycle bitslip pulse to all deserialisers
//  FrmAlignDone out 1          frame aligned and locked
//  FrmAlignErr  out 1          no alignment found within MAX_SLIPS slips
//  FrmSlipCnt   out 4          slips issued since the last (re)start
//  FrmLockLost  out 1          one-cycle pulse on loss of lock (monitor only, else tied 0)
// BEHAVIOUR
//  - All outputs are registered. Reset (FrmRstN=0) forces all outputs to 0 and the FSM to SETTLE
//    with the settle counter = SETTLE_CYCLES, match counter = 0, slip counter = 0.
//  - States: SETTLE, CHECK, SLIP, LOCKED, FAIL.
//  - SETTLE: count down; after SETTLE_CYCLES cycles -> CHECK.
//  - CHECK: FrmData==FRM_PATTERN increments the match counter. Reaching MATCH_COUNT -> LOCKED.
//    On mismatch the match counter clears. If FrmSlipCnt==MAX_SLIPS -> FAIL, else -> SLIP.
//  - SLIP: FrmBitslip=1 for exactly this one cycle; FrmSlipCnt+1; -> SETTLE (counter reloaded).
//    Bitslip pulses are never back-to-back; the gap is >= SETTLE_CYCLES+1 cycles.
//  - LOCKED: FrmAlignDone=1; FrmSlipCnt frozen; FrmData still compared (see CONFIGURATION).
//  - FAIL: FrmAlignErr=1, FrmAlignDone=0; stays until FrmStart or reset.
//  - Timing with cycle 1 = first FrmClkDiv edge after reset release:
//    - SETTLE occupies cycles 1..SETTLE_CYCLES.
//    - An aligned input gives FrmAlignDone=1 from cycle SETTLE_CYCLES+MATCH_COUNT+1.
//  - FrmStart, in any state: next cycle is SETTLE; Done, Err and FrmSlipCnt clear; match and
//    loss counters clear. FrmStart wins over every simultaneous transition, including a SLIP
//    pulse due that cycle; that bitslip is not issued.
//  - FrmSlipCnt is FrmSlipCnt+1 saturated at 15 and never wraps. MAX_SLIPS bounds it in normal use.
//  - Reset asserted mid-operation (for example during SLIP) clears FrmBitslip asynchronously.
// CONFIGURATION
//  - FRM_ALIGN_MONITOR_EN defined:
//    - In LOCKED, LOSS_COUNT consecutive mismatches pulse FrmLockLost for 1 cycle and clear
//      FrmAlignDone. They also clear FrmSlipCnt and the match counter, then -> SETTLE (realign).
//    - A matching word resets the loss counter.
//  - FRM_ALIGN_MONITOR_EN undefined:
//    - LOCKED is sticky until FrmStart or reset.
//    - FrmLockLost is tied to 0 and no loss counter is built.
// TESTING
//  - T1: FrmData=14'h3F80 constant from reset. Required: no bitslip pulses; FrmAlignDone rises at
//    cycle 13 (4+8+1); FrmSlipCnt=0.
//  - T2: model shifts a rotating frame one bit per bitslip; start offset 5. Required: exactly 5
//    pulses, each 1 cycle wide, spaced 5 cycles apart; Done=1 with FrmSlipCnt=5.
//  - T3: FrmData=14'h0000 forever. Required: 13 pulses, then FrmAlignErr=1, Done=0, FrmSlipCnt=13;
//    a later FrmStart clears Err and slipping resumes.
//  - T4: aligned input that mismatches on the 6th CHECK cycle. Required: the match counter
//    restarts, one bitslip is issued, and lock takes 8 fresh consecutive matches.
//  - T5: FrmStart in the same cycle as a due SLIP. Required: no bitslip pulse; FrmSlipCnt=0 and
//    state SETTLE on the next cycle.
//  - T6: (FRM_ALIGN_MONITOR_EN) lock, then 3 bad words and 1 good word: Done stays 1. Then 4 bad
//    words: FrmLockLost pulses once, Done=0, realignment starts.

Source files
------------

// File: rtl/adc_frame_align.sv
// Frame-clock alignment controller: pulses bitslip until the deserialised frame word equals
// FRM_PATTERN, then holds lock. Define FRM_ALIGN_MONITOR_EN to build the post-lock loss monitor.
module adc_frame_align #(
  parameter int                   FRM_WIDTH     = 14,
  parameter logic [FRM_WIDTH-1:0] FRM_PATTERN   = 14'b11111110000000,
  parameter int                   SETTLE_CYCLES = 4,
  parameter int                   MATCH_COUNT   = 8,
  parameter int                   MAX_SLIPS     = 13,
  parameter int                   LOSS_COUNT    = 4
) (
  input  logic                 FrmClkDiv,
  input  logic                 FrmRstN,
  input  logic                 FrmStart,
  input  logic [FRM_WIDTH-1:0] FrmData,
  output logic                 FrmBitslip,
  output logic                 FrmAlignDone,
  output logic                 FrmAlignErr,
  output logic [3:0]           FrmSlipCnt,
  output logic                 FrmLockLost
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [3:0]    SLIP_LIMIT  = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAIL} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [3:0]    slip_q, slip_d;
  logic          bitslip_q, bitslip_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          frm_match;

  assign frm_match = (FrmData == FRM_PATTERN);

`ifdef FRM_ALIGN_MONITOR_EN
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);
  logic [LW-1:0] loss_q, loss_d;
  logic          lost_q, lost_d;
`endif

  always_ff @(posedge FrmClkDiv or negedge FrmRstN) begin
    if (!FrmRstN) begin
      state_q   <= S_SETTLE;
      settle_q  <= SETTLE_LOAD;
      match_q   <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // FrmStart overrides every transition, so a slip decided in the same cycle is dropped.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slip_d   = slip_q;
`ifdef FRM_ALIGN_MONITOR_EN
    loss_d   = loss_q;
`endif
    if (FrmStart) begin
      state_d  = S_SETTLE;
      settle_d = SETTLE_LOAD;
      match_d  = '0;
      slip_d   = '0;
`ifdef FRM_ALIGN_MONITOR_EN
      loss_d   = '0;
`endif
    end else begin
      unique case (state_q)
        S_SETTLE: begin
          if (settle_q <= SW'(1)) state_d = S_CHECK;
          else                    settle_d = settle_q - SW'(1);
        end
        S_CHECK: begin
          if (frm_match) begin
            match_d = match_q + MW'(1);
            if (match_q == MATCH_LAST) state_d = S_LOCKED;
          end else begin
            match_d = '0;
            if (slip_q == SLIP_LIMIT) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_SLIP;
              slip_d  = (slip_q == 4'hF) ? slip_q : slip_q + 4'd1;
            end
          end
        end
        S_SLIP: begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_LOAD;
        end
        S_LOCKED: begin
`ifdef FRM_ALIGN_MONITOR_EN
          if (frm_match) begin
            loss_d = '0;
          end else if (loss_q == LOSS_LAST) begin
            state_d  = S_SETTLE;
            settle_d = SETTLE_LOAD;
            match_d  = '0;
            slip_d   = '0;
            loss_d   = '0;
          end else begin
            loss_d = loss_q + LW'(1);
          end
`endif
        end
        S_FAIL: begin
        end
        default: state_d = S_SETTLE;
      endcase
    end
  end

  // Outputs are registered copies of the state being entered.
  always_comb begin
    bitslip_d = (state_d == S_SLIP);
    done_d    = (state_d == S_LOCKED);
    err_d     = (state_d == S_FAIL);
  end

`ifdef FRM_ALIGN_MONITOR_EN
  assign lost_d = (state_q == S_LOCKED) && (state_d == S_SETTLE) && !FrmStart;

  always_ff @(posedge FrmClkDiv or negedge FrmRstN) begin
    if (!FrmRstN) begin
      loss_q <= '0;
      lost_q <= 1'b0;
    end else begin
      loss_q <= loss_d;
      lost_q <= lost_d;
    end
  end

  assign FrmLockLost = lost_q;
`else
  assign FrmLockLost = 1'b0;
`endif

  assign FrmBitslip   = bitslip_q;
  assign FrmAlignDone = done_q;
  assign FrmAlignErr  = err_q;
  assign FrmSlipCnt   = slip_q;

endmodule
